// File: rtl/cache_checker_pkg.sv
// Shared types for the cache traffic checker: trace word layout, FSM states
// and the wrap-safe latency helper used by the optional latency statistics.
package cache_checker_pkg;

   localparam int unsigned TW_ADDR_W = 20;
   localparam int unsigned TW_DATA_W = 32;
   localparam int unsigned STAMP_W   = 16;

   typedef struct packed {
      logic                 rw;
      logic [TW_ADDR_W-1:0] addr;
      logic [TW_DATA_W-1:0] data;
   } trace_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } checker_state_t;

   // Elapsed cycles between two free-running stamps, modulo 2^STAMP_W.
   function automatic logic [STAMP_W-1:0] latency_of(input logic [STAMP_W-1:0] now,
                                                     input logic [STAMP_W-1:0] stamp);
      return now - stamp;
   endfunction

endpackage

// File: rtl/checker_fifo.sv
// Synchronous FIFO holding expected read data; pointers carry one extra bit
// so full and empty are distinguished without a separate counter.
module checker_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_push = push & ~full & ~clr;
   assign do_pop  = pop & ~empty & ~clr;
   assign head    = mem[rd_ptr[AW-1:0]];

   // Pointer update; clear discards all entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; contents need no reset because empty masks them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/cache_traffic_checker.sv
// Trace-driven traffic generator and in-order read checker for sa_cache.
// Optional feature macro: CHECKER_LATENCY_STATS_EN adds per-entry push
// timestamps and a max_latency output.
module cache_traffic_checker
   import cache_checker_pkg::*;
#(
   parameter int unsigned ADDR_W   = 20,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned TRACE_AW = 10,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned ERR_W    = 16,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [CNT_W-1:0]           num_req,
   output logic [TRACE_AW-1:0]        trace_addr,
   input  logic [ADDR_W+DATA_W:0]     trace_data,
   output logic                       req_valid,
   output logic                       req_rw,
   output logic [ADDR_W-1:0]          req_addr,
   output logic [DATA_W-1:0]          req_data,
   input  logic                       cache_stopped,
   input  logic                       cache_ready,
   input  logic [DATA_W-1:0]          cache_data,
   output logic                       gold_we,
   output logic [ADDR_W-1:0]          gold_addr,
   output logic [DATA_W-1:0]          gold_din,
   input  logic [DATA_W-1:0]          gold_dout,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [ERR_W-1:0]           err_count,
   output logic                       timeout
`ifdef CHECKER_LATENCY_STATS_EN
   ,
   output logic [STAMP_W-1:0]         max_latency
`endif
);

   localparam int unsigned TW = 1 + ADDR_W + DATA_W;
   localparam int unsigned IW = $clog2(TIMEOUT + 1);
`ifdef CHECKER_LATENCY_STATS_EN
   localparam int unsigned FW = DATA_W + STAMP_W;
`else
   localparam int unsigned FW = DATA_W;
`endif

   checker_state_t    state;
   checker_state_t    state_nx;
   logic [CNT_W-1:0]  issued;
   logic [CNT_W-1:0]  num_req_q;
   logic [ERR_W-1:0]  err_q;
   logic              underflow_q;
   logic              timeout_q;
   logic [IW-1:0]     idle_cnt;

   logic              fifo_full;
   logic              fifo_empty;
   logic [FW-1:0]     fifo_din;
   logic [FW-1:0]     fifo_head;

   logic              start_ok;
   logic              accept;
   logic              push;
   logic              pop;
   logic              underflow_ev;
   logic              mismatch;
   logic              last_accept;
   logic              wd_fire;

   // Request fields come straight from the trace word.
   assign req_rw    = trace_data[TW-1];
   assign req_addr  = trace_data[DATA_W +: ADDR_W];
   assign req_data  = trace_data[DATA_W-1:0];
   assign gold_addr = req_addr;
   assign gold_din  = req_data;

   // Handshake and FIFO event decode.
   assign req_valid    = (state == RUN) & ~fifo_full;
   assign accept       = req_valid & ~cache_stopped;
   assign gold_we      = accept & req_rw;
   assign push         = accept & ~req_rw;
   assign start_ok     = start & ((state == IDLE) | (state == DONE));
   assign pop          = cache_ready & ~fifo_empty;
   assign underflow_ev = cache_ready & fifo_empty;
   assign mismatch     = pop & (fifo_head[DATA_W-1:0] != cache_data);
   assign last_accept  = accept & ((issued + CNT_W'(1)) == num_req_q);
   assign wd_fire      = (state == DRAIN) & ~fifo_empty & ~pop &
                         (idle_cnt == IW'(TIMEOUT - 1));

   assign busy      = (state == RUN) | (state == DRAIN);
   assign done      = (state == DONE);
   assign pass      = done & (err_q == '0) & ~timeout_q & ~underflow_q;
   assign err_count = err_q;
   assign timeout   = timeout_q;

`ifdef CHECKER_LATENCY_STATS_EN
   logic [STAMP_W-1:0] now;
   logic [STAMP_W-1:0] lat;

   assign fifo_din = {now, gold_dout};
   assign lat      = latency_of(now, fifo_head[FW-1 -: STAMP_W]);

   // Free-running timestamp source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) now <= '0;
      else     now <= now + STAMP_W'(1);
   end

   // Running maximum of pop latency, cleared when a run starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           max_latency <= '0;
      else if (start_ok)                 max_latency <= '0;
      else if (pop && lat > max_latency) max_latency <= lat;
   end
`else
   assign fifo_din = gold_dout;
`endif

   checker_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_ok),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start) state_nx = (num_req == '0) ? DONE : RUN;
         RUN:        if (last_accept) state_nx = DRAIN;
         DRAIN:      if (fifo_empty || wd_fire) state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   // Run counters, error tracking and drain watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trace_addr  <= '0;
         issued      <= '0;
         num_req_q   <= '0;
         err_q       <= '0;
         underflow_q <= 1'b0;
         timeout_q   <= 1'b0;
         idle_cnt    <= '0;
      end else if (start_ok) begin
         trace_addr  <= '0;
         issued      <= '0;
         num_req_q   <= num_req;
         err_q       <= '0;
         underflow_q <= 1'b0;
         timeout_q   <= 1'b0;
         idle_cnt    <= '0;
      end else begin
         if (accept) begin
            trace_addr <= trace_addr + TRACE_AW'(1);
            issued     <= issued + CNT_W'(1);
         end
         if ((mismatch || underflow_ev) && (err_q != {ERR_W{1'b1}}))
            err_q <= err_q + ERR_W'(1);
         if (underflow_ev) underflow_q <= 1'b1;
         if (wd_fire)      timeout_q   <= 1'b1;
         if (state != DRAIN || pop) idle_cnt <= '0;
         else if (!wd_fire)         idle_cnt <= idle_cnt + IW'(1);
      end
   end

endmodule

// File: tb/tb_cache_traffic_checker.sv
// Self-checking bench for cache_traffic_checker: trace/golden memories, a
// behavioural cache with random stalls and response delays, and a reference
// model that replays the trace to predict golden contents and error counts.
module tb_cache_traffic_checker;

   localparam int ADDR_W   = 20;
   localparam int DATA_W   = 32;
   localparam int TRACE_AW = 10;
   localparam int CNT_W    = 16;
   localparam int ERR_W    = 16;
   localparam int TW       = 1 + ADDR_W + DATA_W;
   localparam int TDEPTH   = 1 << TRACE_AW;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [CNT_W-1:0]    num_req;
   logic [TRACE_AW-1:0] trace_addr;
   logic [TW-1:0]       trace_data;
   logic                req_valid, req_rw;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_data;
   logic                cache_stopped, cache_ready;
   logic [DATA_W-1:0]   cache_data;
   logic                gold_we;
   logic [ADDR_W-1:0]   gold_addr;
   logic [DATA_W-1:0]   gold_din, gold_dout;
   logic                busy, done, pass, timeout;
   logic [ERR_W-1:0]    err_count;
`ifdef CHECKER_LATENCY_STATS_EN
   logic [15:0]         max_latency;
`endif

   cache_traffic_checker dut (
      .clk(clk), .rst(rst), .start(start), .num_req(num_req),
      .trace_addr(trace_addr), .trace_data(trace_data),
      .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
      .cache_stopped(cache_stopped), .cache_ready(cache_ready), .cache_data(cache_data),
      .gold_we(gold_we), .gold_addr(gold_addr), .gold_din(gold_din), .gold_dout(gold_dout),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .timeout(timeout)
`ifdef CHECKER_LATENCY_STATS_EN
      , .max_latency(max_latency)
`endif
   );

   always #5 clk = ~clk;

   // External memories; addresses used by the traces stay below 256.
   bit [TW-1:0] trace_mem [TDEPTH];
   bit [31:0]   gold_mem  [256];
   bit [31:0]   cmem      [256];
   bit [31:0]   model_mem [256];

   assign trace_data = trace_mem[trace_addr];
   assign gold_dout  = gold_mem[gold_addr[7:0]];

   always @(posedge clk) if (gold_we) gold_mem[gold_addr[7:0]] <= gold_din;

   // Behavioural cache: in-order read responses, random stall and delay.
   bit [31:0] rq [$];
   bit [31:0] cd;
   int        resp_total = 0;
   int        corrupt_upto = 0;
   int        drop_idx = -1;
   int        stall_pct = 0;
   int        resp_pct = 100;
   bit        resp_en = 1'b1;
   bit        stall_force = 1'b0;
   bit        inject_ready = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rq.delete();
         cache_ready   <= 1'b0;
         cache_data    <= '0;
         cache_stopped <= 1'b0;
      end else begin
         cache_ready <= 1'b0;
         if (inject_ready) begin
            cache_ready <= 1'b1;
            cache_data  <= $urandom;
         end else if (resp_en && rq.size() > 0 && $urandom_range(0, 99) < resp_pct) begin
            cd = rq.pop_front();
            if (resp_total != drop_idx) begin
               cache_ready <= 1'b1;
               cache_data  <= (resp_total < corrupt_upto) ? ((cd != 0) ? 32'h0 : 32'h1) : cd;
            end
            resp_total++;
         end
         if (req_valid && !cache_stopped) begin
            if (req_rw) cmem[req_addr[7:0]] = req_data;
            else        rq.push_back(cmem[req_addr[7:0]]);
         end
         cache_stopped <= stall_force || ($urandom_range(0, 99) < stall_pct);
      end
   end

   int total = 0;
   int bad   = 0;
   int run_n, run_base, exp_reads, cycles;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input int idx, input bit rw, input int addr, input bit [31:0] data);
      cache_checker_pkg::trace_word_t tw;
      tw.rw   = rw;
      tw.addr = 20'(addr);
      tw.data = data;
      trace_mem[idx] = tw;
   endtask

   task automatic fill_random(input int read_pct);
      for (int i = 0; i < TDEPTH; i++)
         put(i, $urandom_range(0, 99) >= read_pct, $urandom_range(0, 255), $urandom);
   endtask

   // Replays the first n trace words to predict golden contents and reads,
   // then pulses start.
   task automatic start_run(input int n, input int k_corrupt);
      cache_checker_pkg::trace_word_t tw;
      exp_reads = 0;
      for (int i = 0; i < n; i++) begin
         tw = trace_mem[i % TDEPTH];
         if (tw.rw) model_mem[tw.addr[7:0]] = tw.data;
         else       exp_reads++;
      end
      run_n        = n;
      run_base     = resp_total;
      corrupt_upto = resp_total + k_corrupt;
      @(negedge clk);
      num_req = 16'(n);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      cycles = 0;
      while (done !== 1'b1 && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      check("run_completes", done, 1);
   endtask

   task automatic finish_run(input int budget, input int exp_err, input bit exp_to,
                             input int exp_resp);
      int mm;
      wait_done(budget);
      check("pass", pass, (exp_err == 0 && !exp_to) ? 1 : 0);
      check("err_count", err_count, exp_err);
      check("timeout", timeout, exp_to);
      check("busy_after_done", busy, 0);
      check("trace_addr_final", trace_addr, run_n % TDEPTH);
      check("responses", resp_total - run_base - ((drop_idx >= run_base) ? 1 : 0), exp_resp);
      mm = 0;
      for (int a = 0; a < 256; a++) if (gold_mem[a] != model_mem[a]) mm++;
      check("gold_image", mm, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_watchdog observed=no_finish expected=finish");
      $fatal(1);
   end

   initial begin
      int k, n, m;
      rst = 1'b1; start = 1'b0; num_req = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state.
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_count, 0);
      check("rst_timeout", timeout, 0);
      check("rst_trace_addr", trace_addr, 0);
      check("rst_req_valid", req_valid, 0);
      check("rst_gold_we", gold_we, 0);

      // Response while idle is an underflow.
      inject_ready = 1'b1;
      @(negedge clk);
      inject_ready = 1'b0;
      @(negedge clk);
      check("idle_underflow_err", err_count, 1);
      check("idle_underflow_pass", pass, 0);

      // Zero-length run goes straight to DONE and clears the underflow.
      start_run(0, 0);
      finish_run(4, 0, 0, 0);

      // Write then read back the same address.
      put(0, 1'b1, 'h10, 32'hDEADBEEF);
      put(1, 1'b0, 'h10, 32'h0);
      start_run(2, 0);
      finish_run(20, 0, 0, 1);
      check("short_run_latency", cycles <= 6, 1);

      // Stall held on the first request.
      fill_random(50);
      put(0, 1'b1, 'h33, 32'hCAFEF00D);
      stall_force = 1'b1;
      start_run(40, 0);
      for (int c = 0; c < 5; c++) begin
         check("stall_req_valid", req_valid, 1);
         check("stall_trace_addr", trace_addr, 0);
         check("stall_gold_we", gold_we, 0);
         @(negedge clk);
      end
      stall_force = 1'b0;
      finish_run(400, 0, 0, exp_reads);

      // Twelve reads with responses withheld: issue throttles at FIFO depth.
      for (int i = 0; i < 12; i++) put(i, 1'b0, $urandom_range(0, 255), 32'h0);
      resp_en = 1'b0;
      start_run(12, 0);
      repeat (20) @(negedge clk);
      check("full_trace_addr", trace_addr, 8);
      check("full_req_valid", req_valid, 0);
      check("full_busy", busy, 1);
      resp_en = 1'b1;
      finish_run(200, 0, 0, 12);

      // Corrupted response, then an underflow while in DONE.
      put(0, 1'b1, 'h20, 32'h12345678);
      put(1, 1'b0, 'h20, 32'h0);
      start_run(2, 1);
      finish_run(20, 1, 0, 1);
      inject_ready = 1'b1;
      @(negedge clk);
      inject_ready = 1'b0;
      @(negedge clk);
      check("done_underflow_err", err_count, 2);
      check("done_underflow_pass", pass, 0);

      // Dropped response leaves the FIFO non-empty: drain watchdog fires.
      for (int i = 0; i < 3; i++) put(i, 1'b0, $urandom_range(0, 255), 32'h0);
      drop_idx = resp_total + 1;
      start_run(3, 0);
      finish_run(1200, 0, 1, 2);
      check("timeout_latency", (cycles >= 1024 && cycles <= 1040), 1);
      drop_idx = -1;

      // Asynchronous reset with three reads outstanding.
      for (int i = 0; i < 12; i++) put(i, 1'b0, $urandom_range(0, 255), 32'h0);
      resp_en = 1'b0;
      start_run(12, 0);
      m = 0;
      while (trace_addr !== 10'd3 && m < 20) begin
         @(negedge clk);
         m++;
      end
      check("pre_reset_trace_addr", trace_addr, 3);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_req_valid", req_valid, 0);
      check("mid_rst_trace_addr", trace_addr, 0);
      check("mid_rst_gold_we", gold_we, 0);
      check("mid_rst_err", err_count, 0);
      @(negedge clk);
      rst = 1'b0;
      resp_en = 1'b1;
      fill_random(50);
      start_run(20, 0);
      finish_run(300, 0, 0, exp_reads);

      // Randomised runs with stalls, delayed responses and corruption.
      for (int r = 0; r < 5; r++) begin
         fill_random($urandom_range(20, 80));
         stall_pct = $urandom_range(0, 40);
         resp_pct  = $urandom_range(30, 100);
         n = $urandom_range(20, 200);
         k = $urandom_range(0, 2);
         start_run(n, k);
         finish_run(20 * n + 100, (k < exp_reads) ? k : exp_reads, 0, exp_reads);
      end

      // Run longer than the trace: the trace pointer wraps.
      fill_random(50);
      stall_pct = 10;
      resp_pct  = 80;
      start_run(1100, 0);
      finish_run(10000, 0, 0, exp_reads);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
